// File: rtl/servant_loader_pkg.sv
// Shared definitions for the servant Wishbone boot loader: FSM state
// encodings, lane count and a byte-lane mask helper.
package servant_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_VERIFY  = 3'd3,
    S_DONE    = 3'd4
  } loader_state_t;

  localparam int LANES = 4;

  // Expand a 4-bit byte-select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int k = 0; k < LANES; k++) begin
      mask[8*k +: 8] = {8{sel[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/servant_loader_packer.sv
// Little-endian byte packer: tracks the next free byte lane and accumulates
// data and lane selects for one 32-bit word. word_nxt/sel_nxt show the word
// including the byte being pushed this cycle, so the issuing logic can
// capture a complete word on the same edge that accepts its final byte.
module servant_loader_packer
  import servant_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        clr,
  input  logic [7:0]  data,
  output logic [31:0] word_nxt,
  output logic [3:0]  sel_nxt,
  output logic        last_lane
);

  logic [1:0]  lane_r;
  logic [31:0] dat_r;
  logic [3:0]  sel_r;

  assign last_lane = (lane_r == 2'd3);

  // Merge the incoming byte into its lane of the accumulated word.
  always_comb begin
    word_nxt = dat_r;
    sel_nxt  = sel_r;
    if (push) begin
      word_nxt[{lane_r, 3'b000} +: 8] = data;
      sel_nxt[lane_r]                 = 1'b1;
    end else begin
      word_nxt = dat_r;
      sel_nxt  = sel_r;
    end
  end

  // Lane counter and accumulator; a word issue empties the packer.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_r <= 2'd0;
      dat_r  <= 32'h0000_0000;
      sel_r  <= 4'h0;
    end else if (push) begin
      lane_r <= lane_r + 2'd1;
      dat_r  <= word_nxt;
      sel_r  <= sel_nxt;
    end
  end

endmodule

// File: rtl/servant_wb_loader.sv
// Wishbone initiator that fills servant_ram from a boot byte stream.
// Bytes are packed little-endian into words written at incrementing word
// addresses from 0. Optional read-back verification of every written word
// is enabled by defining SERVANT_LOADER_VERIFY_EN.
module servant_wb_loader
  import servant_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_valid,
  input  logic          i_byte_last,
  output logic          o_byte_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int          WORDS_I = depth / LANES;
  localparam logic [aw-1:0] WORDS_W = WORDS_I[aw-1:0];

  loader_state_t state_r;
  logic [aw-2:0] word_cnt_r;  // one bit wider than the address: holds "RAM full"
  logic          last_r;

  logic          accept_s;
  logic          ovf_s;
  logic          push_s;
  logic          issue_s;
  logic [31:0]   pk_word_s;
  logic [3:0]    pk_sel_s;
  logic          pk_last_lane_s;

`ifdef SERVANT_LOADER_VERIFY_EN
  logic [3:0]    vsel_r;      // lanes of the word being verified
`else
  logic          unused_rdt;
  assign unused_rdt = ^i_wb_rdt;
`endif

  assign accept_s = i_byte_valid & o_byte_ready;
  assign ovf_s    = (word_cnt_r == WORDS_W[aw-2:0]);
  assign push_s   = accept_s & ~ovf_s;
  assign issue_s  = push_s & (pk_last_lane_s | i_byte_last);

  servant_loader_packer u_packer (
    .clk       (i_wb_clk),
    .rst       (i_wb_rst),
    .push      (push_s),
    .clr       (issue_s),
    .data      (i_byte),
    .word_nxt  (pk_word_s),
    .sel_nxt   (pk_sel_s),
    .last_lane (pk_last_lane_s)
  );

  // Loader FSM with address counter, registered Wishbone and status outputs.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_r      <= S_IDLE;
      word_cnt_r   <= '0;
      last_r       <= 1'b0;
      o_byte_ready <= 1'b1;
      o_wb_adr     <= '0;
      o_wb_dat     <= 32'h0000_0000;
      o_wb_sel     <= 4'h0;
      o_wb_we      <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
`ifdef SERVANT_LOADER_VERIFY_EN
      vsel_r       <= 4'h0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state_r)
        S_IDLE, S_COLLECT: begin
          if (accept_s) begin
            o_busy <= 1'b1;
            if (ovf_s) begin
              // RAM already full: swallow the byte, flag it, finish on last.
              o_err <= 1'b1;
              if (i_byte_last) begin
                state_r      <= S_DONE;
                o_done       <= 1'b1;
                o_busy       <= 1'b0;
                o_byte_ready <= 1'b0;
              end else begin
                state_r <= S_COLLECT;
              end
            end else if (issue_s) begin
              state_r      <= S_WRITE;
              last_r       <= i_byte_last;
              o_byte_ready <= 1'b0;
              o_wb_cyc     <= 1'b1;
              o_wb_we      <= 1'b1;
              o_wb_adr     <= word_cnt_r[aw-3:0];
              o_wb_dat     <= pk_word_s;
              o_wb_sel     <= pk_sel_s;
            end else begin
              state_r <= S_COLLECT;
            end
          end
        end
        S_WRITE: begin
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
`ifdef SERVANT_LOADER_VERIFY_EN
            state_r  <= S_VERIFY;
            o_wb_we  <= 1'b0;
            o_wb_sel <= 4'hf;
            vsel_r   <= o_wb_sel;
`else
            word_cnt_r <= word_cnt_r + 1'b1;
            if (last_r) begin
              state_r <= S_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state_r      <= S_COLLECT;
              o_byte_ready <= 1'b1;
            end
`endif
          end
        end
`ifdef SERVANT_LOADER_VERIFY_EN
        S_VERIFY: begin
          // One idle cycle after the write ack, then a read of the same word.
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
          end else if (i_wb_ack) begin
            o_wb_cyc   <= 1'b0;
            word_cnt_r <= word_cnt_r + 1'b1;
            if (|((i_wb_rdt ^ o_wb_dat) & lane_mask(vsel_r))) begin
              o_err <= 1'b1;
            end
            if (last_r) begin
              state_r <= S_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state_r      <= S_COLLECT;
              o_byte_ready <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state_r      <= S_IDLE;
          word_cnt_r   <= '0;
          last_r       <= 1'b0;
          o_byte_ready <= 1'b1;
        end
        default: begin
          state_r      <= S_IDLE;
          o_wb_cyc     <= 1'b0;
          o_byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_wb_loader.sv
// Self-checking bench for servant_wb_loader (depth 256) with a behavioural
// Wishbone RAM and a reference model of the expected word writes.
module tb_servant_wb_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        byte_ready;
  logic [5:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt = 32'h0;
  logic        wb_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int max_adr = 0;

  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [31:0] exp_mem [0:63] = '{default: 32'h0};
  logic [31:0] flip_mask = 32'h0;

  int          wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [3:0]  wr_sel_q[$];
  int          rd_adr_q[$];
  logic [7:0]  img_q[$];
  logic [31:0] exp_dat_q[$];
  logic [3:0]  exp_sel_q[$];

  always #5 clk = ~clk;

  servant_wb_loader #(.depth(256)) dut (
    .i_wb_clk     (clk),
    .i_wb_rst     (rst),
    .i_byte       (in_byte),
    .i_byte_valid (in_valid),
    .i_byte_last  (in_last),
    .o_byte_ready (byte_ready),
    .o_wb_adr     (wb_adr),
    .o_wb_dat     (wb_dat),
    .o_wb_sel     (wb_sel),
    .o_wb_we      (wb_we),
    .o_wb_cyc     (wb_cyc),
    .i_wb_rdt     (wb_rdt),
    .i_wb_ack     (wb_ack),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // Wishbone RAM: acks one cycle after cyc, logs every access.
  always @(posedge clk) begin
    if (rst) begin
      wb_ack <= 1'b0;
    end else if (wb_cyc && !wb_ack) begin
      wb_ack <= 1'b1;
      if (wb_we) begin
        for (int k = 0; k < 4; k++)
          if (wb_sel[k]) mem[wb_adr][8*k +: 8] <= wb_dat[8*k +: 8];
        wr_adr_q.push_back(int'(wb_adr));
        wr_dat_q.push_back(wb_dat);
        wr_sel_q.push_back(wb_sel);
      end else begin
        wb_rdt <= mem[wb_adr] ^ flip_mask;
        rd_adr_q.push_back(int'(wb_adr));
      end
    end else begin
      wb_ack <= 1'b0;
    end
  end

  // Bus protocol monitor, sampled mid-cycle.
  logic        ack_prev = 1'b0;
  logic        cyc_prev = 1'b0;
  logic [42:0] bus_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (wb_cyc && wb_we && int'(wb_adr) > max_adr) max_adr = int'(wb_adr);
      if (ack_prev) begin
        checks++;
        if (wb_cyc !== 1'b0) begin errors++; $display("FAIL cyc_after_ack cyc=%b required=0", wb_cyc); end
      end
      if (wb_cyc) begin
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL ready_during_cycle ready=%b required=0", byte_ready); end
      end
      if (cyc_prev && wb_cyc) begin
        checks++;
        if ({wb_we, wb_adr, wb_dat, wb_sel} !== bus_prev) begin
          errors++; $display("FAIL bus_stable got=%h required=%h", {wb_we, wb_adr, wb_dat, wb_sel}, bus_prev);
        end
      end
    end
    ack_prev = rst ? 1'b0 : wb_ack;
    cyc_prev = rst ? 1'b0 : wb_cyc;
    bus_prev = {wb_we, wb_adr, wb_dat, wb_sel};
  end

  // Reference model: words expected from img_q, and resulting RAM image.
  task automatic model_image();
    int n;
    logic [31:0] d;
    logic [3:0]  s;
    exp_dat_q.delete();
    exp_sel_q.delete();
    n = img_q.size();
    for (int w = 0; w < (n + 3) / 4 && w < 64; w++) begin
      d = 32'h0;
      s = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) begin
          d = d | (32'(img_q[4 * w + k]) << (8 * k));
          s[k] = 1'b1;
          exp_mem[w][8*k +: 8] = img_q[4 * w + k];
        end
      end
      exp_dat_q.push_back(d);
      exp_sel_q.push_back(s);
    end
  endtask

  task automatic clear_logs();
    wr_adr_q.delete(); wr_dat_q.delete(); wr_sel_q.delete(); rd_adr_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic l);
    int t;
    @(negedge clk);
    in_byte = b; in_valid = 1'b1; in_last = l;
    t = 0;
    while (byte_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++; $display("FAIL push_timeout ready=%b required=1", byte_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_image();
    for (int i = 0; i < img_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); in_valid = 1'b0; in_last = 1'b0; end
      push_byte(img_q[i], i == img_q.size() - 1);
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 1000) begin @(negedge clk); t++; end
    checks++;
    if (done_cnt == base) begin errors++; $display("FAIL done_timeout done_cnt=%0d required=%0d", done_cnt, base + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", byte_ready); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got=%b required=0", wb_cyc); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b required=0", wb_we); end
    checks++; if (wb_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got=%h required=0", wb_sel); end
    checks++; if (wb_adr !== 6'd0) begin errors++; $display("FAIL reset_adr got=%0d required=0", wb_adr); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status busy/done/err=%b required=000", {busy, done, err}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fixed_words();
    int base;
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (wr_adr_q.size() != 2) begin errors++; $display("FAIL fixed_write_count got=%0d required=2", wr_adr_q.size()); end
    checks++; if (mem[0] !== 32'h44332211) begin errors++; $display("FAIL fixed_mem0 got=%h required=44332211", mem[0]); end
    checks++; if (mem[1] !== 32'h88776655) begin errors++; $display("FAIL fixed_mem1 got=%h required=88776655", mem[1]); end
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL fixed_done_once got=%0d required=%0d", done_cnt - base, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_after got=%b required=0", busy); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL fixed_ready_after got=%b required=1", byte_ready); end
  endtask

  task automatic test_partial_word();
    int base;
    img_q = '{8'hAA, 8'hBB, 8'hCC};
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (wr_adr_q.size() != 1) begin errors++; $display("FAIL partial_write_count got=%0d required=1", wr_adr_q.size()); end
    if (wr_adr_q.size() > 0) begin
      checks++; if (wr_adr_q[0] != 0) begin errors++; $display("FAIL partial_adr got=%0d required=0", wr_adr_q[0]); end
      checks++; if (wr_sel_q[0] !== 4'b0111) begin errors++; $display("FAIL partial_sel got=%b required=0111", wr_sel_q[0]); end
      checks++; if (wr_dat_q[0] !== 32'h00CCBBAA) begin errors++; $display("FAIL partial_dat got=%h required=00ccbbaa", wr_dat_q[0]); end
    end
    checks++; if (mem[0] !== 32'h44CCBBAA) begin errors++; $display("FAIL partial_mem0 got=%h required=44ccbbaa", mem[0]); end
  endtask

  task automatic test_random_images();
    int base;
    int n;
    for (int img = 0; img < 4; img++) begin
      n = $urandom_range(1, 40);
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back(8'($urandom));
      clear_logs(); model_image();
      base = done_cnt;
      send_image(); wait_done(base);
      checks++;
      if (wr_adr_q.size() != exp_dat_q.size()) begin
        errors++; $display("FAIL random_write_count img=%0d got=%0d required=%0d", img, wr_adr_q.size(), exp_dat_q.size());
      end else begin
        for (int w = 0; w < exp_dat_q.size(); w++) begin
          checks++;
          if (wr_adr_q[w] != w || wr_dat_q[w] !== exp_dat_q[w] || wr_sel_q[w] !== exp_sel_q[w] || mem[w] !== exp_mem[w]) begin
            errors++;
            $display("FAIL random_word img=%0d w=%0d adr=%0d dat=%h sel=%b mem=%h required adr=%0d dat=%h sel=%b mem=%h",
                     img, w, wr_adr_q[w], wr_dat_q[w], wr_sel_q[w], mem[w], w, exp_dat_q[w], exp_sel_q[w], exp_mem[w]);
          end
        end
      end
      checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL random_done_once got=%0d required=1", done_cnt - base); end
      checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL random_status busy/err=%b required=00", {busy, err}); end
    end
  endtask

  task automatic test_overflow();
    int base;
    img_q.delete();
    for (int i = 0; i < 260; i++) img_q.push_back(8'($urandom));
    clear_logs(); model_image();
    max_adr = 0;
    base = done_cnt;
    for (int i = 0; i < 260; i++) begin
      push_byte(img_q[i], i == 259);
      if (i == 255) begin
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got=%b required=0", err); end
      end
      if (i == 256) begin
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_byte257 got=%b required=1", err); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready got=%b required=1", byte_ready); end
      end
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    wait_done(base);
    checks++; if (wr_adr_q.size() != 64) begin errors++; $display("FAIL ovf_write_count got=%0d required=64", wr_adr_q.size()); end
    for (int w = 0; w < 64; w++) begin
      checks++;
      if (mem[w] !== exp_mem[w]) begin errors++; $display("FAIL ovf_mem w=%0d got=%h required=%h", w, mem[w], exp_mem[w]); end
    end
    checks++; if (max_adr != 63) begin errors++; $display("FAIL ovf_max_adr got=%0d required=63", max_adr); end
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL ovf_done_once got=%0d required=1", done_cnt - base); end
    checks++; if ({busy, err} !== 2'b01) begin errors++; $display("FAIL ovf_status busy/err=%b required=01", {busy, err}); end
  endtask

  task automatic test_reset_mid_cycle();
    int base;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0);
    checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL midrst_cyc_before got=%b required=1", wb_cyc); end
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL midrst_cyc got=%b required=0", wb_cyc); end
    checks++;
    if ({byte_ready, busy, done, err, wb_we, wb_sel} !== 9'b1_0_0_0_0_0000) begin
      errors++; $display("FAIL midrst_outputs got=%b required=100000000", {byte_ready, busy, done, err, wb_we, wb_sel});
    end
    @(negedge clk); rst = 1'b0;
    img_q = '{8'h5A, 8'hC3, 8'h0F, 8'hE1};
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (wr_adr_q.size() != 1) begin errors++; $display("FAIL midrst_write_count got=%0d required=1", wr_adr_q.size()); end
    if (wr_adr_q.size() > 0) begin
      checks++; if (wr_adr_q[0] != 0) begin errors++; $display("FAIL midrst_adr got=%0d required=0", wr_adr_q[0]); end
    end
    checks++; if (mem[0] !== 32'hE10FC35A) begin errors++; $display("FAIL midrst_mem0 got=%h required=e10fc35a", mem[0]); end
  endtask

`ifdef SERVANT_LOADER_VERIFY_EN
  task automatic test_verify();
    int base;
    flip_mask = 32'h0;
    img_q.delete();
    for (int i = 0; i < 8; i++) img_q.push_back(8'($urandom));
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (rd_adr_q.size() != 2) begin errors++; $display("FAIL verify_read_count got=%0d required=2", rd_adr_q.size()); end
    for (int w = 0; w < rd_adr_q.size() && w < 2; w++) begin
      checks++; if (rd_adr_q[w] != w) begin errors++; $display("FAIL verify_read_adr w=%0d got=%0d required=%0d", w, rd_adr_q[w], w); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL verify_clean_err got=%b required=0", err); end
    flip_mask = 32'h0000_FF00;
    img_q = '{8'h42};
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL verify_unselected_flip got=%b required=0", err); end
    flip_mask = 32'h0000_0100;
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    clear_logs(); model_image();
    base = done_cnt;
    send_image(); wait_done(base);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL verify_flip_err got=%b required=1", err); end
    flip_mask = 32'h0;
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_words();
    test_partial_word();
    test_random_images();
    test_overflow();
    test_reset_mid_cycle();
`ifdef SERVANT_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
